// File: rtl/i2s_tx.sv
// I2S transmitter: divides clk_i into BCLK, frames 2*DATA_WIDTH slots per LRCLK period
// and shifts buffered samples out MSB first with the standard one-bit delay.
module i2s_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int BCLK_DIV   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  empty_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic                  rd_o,
  output logic                  bclk_o,
  output logic                  lrclk_o,
  output logic                  sdata_o,
  output logic                  underrun_o
);

  localparam int DIV_W  = $clog2(BCLK_DIV);
  localparam int SLOT_W = $clog2(2 * DATA_WIDTH);

  localparam logic [DIV_W-1:0]  DIV_LAST    = DIV_W'(BCLK_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST   = SLOT_W'(2 * DATA_WIDTH - 1);
  localparam logic [SLOT_W-1:0] LOAD_LEFT   = SLOT_W'(1);
  localparam logic [SLOT_W-1:0] LOAD_RIGHT  = SLOT_W'(DATA_WIDTH + 1);
  localparam logic [SLOT_W-1:0] RIGHT_START = SLOT_W'(DATA_WIDTH);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t                 state;
  logic [DIV_W-1:0]       div;
  logic [SLOT_W-1:0]      slot;
  logic [SLOT_W-1:0]      next_slot;
  logic                   first;
  logic                   wrap;
  logic                   fall;
  logic                   load;
  logic [DATA_WIDTH-1:0]  shreg;

  // 'first' marks that no slot has started yet, so the first falling edge opens slot 0
  always_comb begin
    wrap      = (div == DIV_LAST);
    fall      = wrap && bclk_o;
    next_slot = '0;
    if (!first && slot != SLOT_LAST) next_slot = slot + SLOT_W'(1);
    load      = (next_slot == LOAD_LEFT) || (next_slot == LOAD_RIGHT);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      div        <= '0;
      slot       <= '0;
      first      <= 1'b1;
      shreg      <= '0;
      bclk_o     <= 1'b0;
      lrclk_o    <= 1'b0;
      sdata_o    <= 1'b0;
      rd_o       <= 1'b0;
      underrun_o <= 1'b0;
    end else begin
      rd_o       <= 1'b0;
      underrun_o <= 1'b0;
      case (state)
        IDLE: begin
          div     <= '0;
          slot    <= '0;
          first   <= 1'b1;
          shreg   <= '0;
          bclk_o  <= 1'b0;
          lrclk_o <= 1'b0;
          sdata_o <= 1'b0;
          if (en_i) state <= RUN;
        end
        RUN: begin
          div <= wrap ? '0 : div + DIV_W'(1);
          if (wrap && !bclk_o) bclk_o <= 1'b1;
          if (fall) begin
            // a stop only takes effect where slot 0 would begin, dropping the last right LSB
            if (next_slot == '0 && !en_i) begin
              state   <= IDLE;
              div     <= '0;
              slot    <= '0;
              first   <= 1'b1;
              shreg   <= '0;
              bclk_o  <= 1'b0;
              lrclk_o <= 1'b0;
              sdata_o <= 1'b0;
            end else begin
              bclk_o  <= 1'b0;
              slot    <= next_slot;
              first   <= 1'b0;
              lrclk_o <= (next_slot >= RIGHT_START);
              if (load) begin
                if (!empty_i) begin
                  sdata_o <= rdata_i[DATA_WIDTH-1];
                  shreg   <= {rdata_i[DATA_WIDTH-2:0], 1'b0};
                  rd_o    <= 1'b1;
                end else begin
                  sdata_o    <= 1'b0;
                  shreg      <= '0;
                  underrun_o <= 1'b1;
                end
              end else begin
                sdata_o <= shreg[DATA_WIDTH-1];
                shreg   <= {shreg[DATA_WIDTH-2:0], 1'b0};
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 Parameter DATA_WIDTH, 16, sample width in bits; slot width equals DATA_WIDTH.
REQ-002 Parameter BCLK_DIV, 4, clk_i cycles per BCLK half-period; legal values are 2 or greater.
REQ-003 clk_i  input  1  the single system clock; all state changes on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous and active-high.
REQ-005 en_i  input  1  run request.
REQ-006 empty_i  input  1  upstream sample buffer empty flag.
REQ-007 rdata_i  input  DATA_WIDTH  upstream buffer head word; show-ahead, valid whenever empty_i is low.
REQ-008 rd_o  output  1  pop strobe to the buffer; one clk_i cycle per word consumed.
REQ-009 bclk_o  output  1  I2S bit clock.
REQ-010 lrclk_o  output  1  I2S word select; low = left, high = right.
REQ-011 sdata_o  output  1  I2S serial data, MSB first.
REQ-012 underrun_o  output  1  one-cycle pulse when a slot load finds the buffer empty.

Function
REQ-013 The block SHALL have two states: IDLE and RUN.
REQ-014 In IDLE, the block SHALL drive bclk_o, lrclk_o, sdata_o, rd_o and underrun_o to 0 and hold all counters at 0.
REQ-015 Transition IDLE->RUN SHALL occur on the first clk_i edge with en_i=1.
REQ-016 In RUN, a divider SHALL count 0..BCLK_DIV-1, toggling bclk_o on wrap; the BCLK period is exactly 2*BCLK_DIV clk_i cycles.
REQ-017 The first bclk_o toggle after entering RUN SHALL be low->high.
REQ-018 Each high->low bclk_o transition (a falling edge) SHALL start a slot. A slot counter n runs 0..2*DATA_WIDTH-1 and wraps to 0.
REQ-019 The first falling edge after entering RUN SHALL start slot 0.
REQ-020 At the start of slot n, lrclk_o SHALL equal (n >= DATA_WIDTH).
REQ-021 Data SHALL use I2S one-bit delay: the MSB of a channel word appears in slot 1 (left) or slot DATA_WIDTH+1 (right). The LSB appears in the first slot of the following channel.
REQ-022 Load SHALL occur in the clk_i cycle that starts slot 1 or slot DATA_WIDTH+1.
  - If empty_i=0: load rdata_i into the shift register and assert rd_o for exactly that one cycle.
  - If empty_i=1: load zero, assert underrun_o for that one cycle, and leave rd_o at 0.
REQ-023 sdata_o SHALL change only in cycles that start a slot and SHALL be stable across each bclk_o rising edge.
REQ-024 Before the first load after entering RUN, sdata_o SHALL be 0.
REQ-025 rd_o SHALL never assert while empty_i=1 and SHALL never assert more than twice per frame.
REQ-026 If en_i is deasserted in RUN, the block SHALL complete the current frame and enter IDLE at the falling edge that would start the next slot 0.
  - The final right-channel LSB is not emitted.
  - No further rd_o SHALL occur after the last slot DATA_WIDTH+1 load.
REQ-027 Re-assertion of en_i before that boundary SHALL cancel the stop.

Reset
REQ-028 While rst_i=1 at a clk_i edge, the block SHALL enter IDLE, clear the divider, slot counter and shift register, and drive all outputs to 0 on that edge.
REQ-029 rst_i SHALL override en_i and any pending load.
  - A reset coinciding with a load cycle produces no rd_o pulse.
  - A reset asserted mid-frame abandons the frame with no further rd_o.
REQ-030 After rst_i falls, behaviour SHALL follow REQ-015 onward as from power-up.

Verification (BCLK_DIV=2, DATA_WIDTH=16: BCLK = 4 clk_i, frame = 128 clk_i)
REQ-031 Hold rst_i=1 for 3 cycles with en_i=1 -> all outputs 0 throughout; no rd_o.
REQ-032 Buffer holds 0xABCD, 0x1234; raise en_i -> rd_o pulses exactly twice in frame 1.
  - Bits sampled on bclk_o rising in slots 1..16 give 0xABCD; slots 17..31 plus next slot 0 give 0x1234.
  - lrclk_o is low for 16 BCLKs, then high for 16.
REQ-033 empty_i=1, en_i=1 for 2 frames -> sdata_o always 0; underrun_o pulses 4 times, 64 clk_i apart; rd_o never asserts.
REQ-034 Feed words 0x0000..0x0007 continuously -> serial output preserves order L0,R1,L2,...; exactly 8 rd_o pulses; bclk_o period exactly 4 clk_i.
REQ-035 Drop en_i at slot 5 -> frame completes; bclk_o, lrclk_o and sdata_o go to 0 at the next slot-0 boundary; no rd_o afterwards.
REQ-036 Assert rst_i for 1 cycle at slot 8 -> outputs 0 on the next edge; no rd_o; with en_i held high after release, slot 0 restarts per REQ-017/REQ-019.
